// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial pattern detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_FILLING  = 2'd1,
        ST_ARMED    = 2'd2
    } state_t;

    // Width needed to hold a length value in 0..max_len.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    localparam int          DEF_MAX_LEN   = 8;
    localparam int          DEF_CNT_W     = 8;
    localparam logic [31:0] DEF_PATTERN_C = 32'h0000_0004;
    localparam int          DEF_LEN_C     = 3;
    localparam bit          DEF_OVERLAP_C = 1'b1;

endpackage

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating up-counter with a clear that wins over an increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Count up on inc, hold at all-ones, clear takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with programmable pattern/length,
// overlap control and a saturating match tally.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = DEF_MAX_LEN,
    parameter int                 CNT_W       = DEF_CNT_W,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DEF_PATTERN_C),
    parameter int                 DEF_LEN     = DEF_LEN_C,
    parameter bit                 DEF_OVERLAP = DEF_OVERLAP_C,
    localparam int                LEN_W       = len_width(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               serial_in,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clear,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               armed,
    output logic               cfg_err
);

    state_t             r_state;
    logic [MAX_LEN-1:0] r_hist;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_fill;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic               r_cfg_err;
    logic               r_match;

    logic [MAX_LEN-1:0] w_hist_next;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W-1:0]   w_fill_next;
    logic               w_cfg_ok;
    logic               w_accept;
    logic               w_full;
    logic               w_hit;
    logic [CNT_W-1:0]   w_count;

    // A load wins over a bit in the same cycle; a disabled detector ignores bits.
    assign w_cfg_ok    = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign w_accept    = in_valid && !cfg_load && (r_state != ST_DISABLED);
    assign w_hist_next = {r_hist[MAX_LEN-2:0], serial_in};
    assign w_fill_next = (r_fill >= LEN_W'(MAX_LEN)) ? r_fill : r_fill + 1'b1;
    assign w_full      = (w_fill_next >= r_len);

    // Select the low len bits of the window; pattern bits above are don't-care.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    assign w_hit = w_accept && w_full && (((w_hist_next ^ r_pattern) & w_mask) == '0);

    // Config latch, history shift, fill tracking and state machine.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_FILLING;
            r_hist    <= '0;
            r_fill    <= '0;
            r_pattern <= DEF_PATTERN;
            r_len     <= LEN_W'(DEF_LEN);
            r_overlap <= DEF_OVERLAP;
            r_cfg_err <= 1'b0;
            r_match   <= 1'b0;
        end else begin
            r_match <= w_hit;
            if (cfg_load) begin
                r_pattern <= cfg_pattern;
                r_len     <= cfg_len;
                r_overlap <= cfg_overlap;
                r_hist    <= '0;
                r_fill    <= '0;
                if (w_cfg_ok) begin
                    r_state   <= ST_FILLING;
                    r_cfg_err <= 1'b0;
                end else begin
                    r_state   <= ST_DISABLED;
                    r_cfg_err <= 1'b1;
                end
            end else if (w_accept) begin
                r_hist <= w_hist_next;
                if (w_hit && !r_overlap) begin
                    // Non-overlap: the completing bit never starts the next match.
                    r_fill  <= '0;
                    r_state <= ST_FILLING;
                end else begin
                    r_fill  <= w_fill_next;
                    r_state <= w_full ? ST_ARMED : ST_FILLING;
                end
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_hit),
        .clr   (cnt_clear),
        .count (w_count)
    );

    assign match       = r_match;
    assign match_count = w_count;
    assign armed       = (r_state == ST_ARMED);
    assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed testbench for seq_pattern_detector.
module tb_seq_pattern_detector;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       serial_in;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       cnt_clear;

    logic       match;
    logic [7:0] match_count;
    logic       armed;
    logic       cfg_err;

    logic       match2;
    logic [1:0] count2;
    logic       armed2;
    logic       cfg_err2;

    int n_pass  = 0;
    int n_total = 0;

    seq_pattern_detector #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .serial_in   (serial_in),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clear   (cnt_clear),
        .match       (match),
        .match_count (match_count),
        .armed       (armed),
        .cfg_err     (cfg_err)
    );

    seq_pattern_detector #(.MAX_LEN(8), .CNT_W(2)) dut2 (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .serial_in   (serial_in),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clear   (cnt_clear),
        .match       (match2),
        .match_count (count2),
        .armed       (armed2),
        .cfg_err     (cfg_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic v, input logic b, input logic clr);
        @(negedge clk);
        in_valid  = v;
        serial_in = b;
        cnt_clear = clr;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        cnt_clear = 1'b0;
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                        input logic v, input logic b);
        @(negedge clk);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        in_valid    = v;
        serial_in   = b;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (match !== 1'b0) $display("FAIL reset_match got %b want 0", match); else n_pass++;
        n_total++; if (match_count !== 8'd0) $display("FAIL reset_count got %0d want 0", match_count); else n_pass++;
        n_total++; if (armed !== 1'b0) $display("FAIL reset_armed got %b want 0", armed); else n_pass++;
        n_total++; if (cfg_err !== 1'b0) $display("FAIL reset_cfg_err got %b want 0", cfg_err); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_default();
        logic [5:0] s, em, ea;
        s = 6'b100100; em = 6'b001001; ea = 6'b001111;
        for (int k = 5; k >= 0; k--) begin
            step(1'b1, s[k], 1'b0);
            n_total++; if (match !== em[k]) $display("FAIL default_match bit%0d got %b want %b", 6 - k, match, em[k]); else n_pass++;
            n_total++; if (armed !== ea[k]) $display("FAIL default_armed bit%0d got %b want %b", 6 - k, armed, ea[k]); else n_pass++;
        end
        n_total++; if (match_count !== 8'd2) $display("FAIL default_count got %0d want 2", match_count); else n_pass++;
    endtask

    task automatic test_overlap();
        logic [4:0] s, em, ea;
        s = 5'b10101; em = 5'b00101; ea = 5'b00111;
        load(8'b101, 4'd3, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        for (int k = 4; k >= 0; k--) begin
            step(1'b1, s[k], 1'b0);
            n_total++; if (match !== em[k]) $display("FAIL overlap_match bit%0d got %b want %b", 5 - k, match, em[k]); else n_pass++;
            n_total++; if (armed !== ea[k]) $display("FAIL overlap_armed bit%0d got %b want %b", 5 - k, armed, ea[k]); else n_pass++;
        end
        n_total++; if (match_count !== 8'd2) $display("FAIL overlap_count got %0d want 2", match_count); else n_pass++;
    endtask

    task automatic test_nonoverlap();
        logic [6:0] s, em, ea;
        s = 7'b1010101; em = 7'b0010001; ea = 7'b0000010;
        load(8'b101, 4'd3, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        for (int k = 6; k >= 0; k--) begin
            step(1'b1, s[k], 1'b0);
            n_total++; if (match !== em[k]) $display("FAIL nonoverlap_match bit%0d got %b want %b", 7 - k, match, em[k]); else n_pass++;
            n_total++; if (armed !== ea[k]) $display("FAIL nonoverlap_armed bit%0d got %b want %b", 7 - k, armed, ea[k]); else n_pass++;
        end
        n_total++; if (match_count !== 8'd2) $display("FAIL nonoverlap_count got %0d want 2", match_count); else n_pass++;
    endtask

    task automatic test_len8_gaps();
        logic [7:0] s, em;
        s = 8'hA5; em = 8'b0000_0001;
        load(8'hA5, 4'd8, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        for (int k = 7; k >= 0; k--) begin
            step(1'b1, s[k], 1'b0);
            n_total++; if (match !== em[k]) $display("FAIL len8_match bit%0d got %b want %b", 8 - k, match, em[k]); else n_pass++;
            step(1'b0, ~s[k], 1'b0);
            n_total++; if (match !== 1'b0) $display("FAIL len8_gap after bit%0d got %b want 0", 8 - k, match); else n_pass++;
        end
        n_total++; if (armed !== 1'b1) $display("FAIL len8_armed got %b want 1", armed); else n_pass++;
        n_total++; if (match_count !== 8'd1) $display("FAIL len8_count got %0d want 1", match_count); else n_pass++;
    endtask

    task automatic test_cfg_priority();
        load(8'b11, 4'd2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        load(8'b11, 4'd2, 1'b1, 1'b1, 1'b1);
        n_total++; if (match !== 1'b0) $display("FAIL prio_load_cycle got %b want 0", match); else n_pass++;
        step(1'b1, 1'b1, 1'b0);
        n_total++; if (match !== 1'b0) $display("FAIL prio_first_bit got %b want 0", match); else n_pass++;
        step(1'b1, 1'b1, 1'b0);
        n_total++; if (match !== 1'b1) $display("FAIL prio_second_bit got %b want 1", match); else n_pass++;
    endtask

    task automatic test_cfg_err();
        logic [5:0] s;
        logic [2:0] s3, em3;
        s = 6'b100100; s3 = 3'b100; em3 = 3'b001;
        load(8'b100, 4'd0, 1'b1, 1'b0, 1'b0);
        n_total++; if (cfg_err !== 1'b1) $display("FAIL err_len0 got %b want 1", cfg_err); else n_pass++;
        n_total++; if (armed !== 1'b0) $display("FAIL err_armed got %b want 0", armed); else n_pass++;
        step(1'b0, 1'b0, 1'b1);
        for (int k = 5; k >= 0; k--) begin
            step(1'b1, s[k], 1'b0);
            n_total++; if (match !== 1'b0) $display("FAIL err_match bit%0d got %b want 0", 6 - k, match); else n_pass++;
        end
        n_total++; if (match_count !== 8'd0) $display("FAIL err_count got %0d want 0", match_count); else n_pass++;
        load(8'b100, 4'd9, 1'b1, 1'b0, 1'b0);
        n_total++; if (cfg_err !== 1'b1) $display("FAIL err_len9 got %b want 1", cfg_err); else n_pass++;
        load(8'b100, 4'd3, 1'b1, 1'b0, 1'b0);
        n_total++; if (cfg_err !== 1'b0) $display("FAIL err_recover got %b want 0", cfg_err); else n_pass++;
        for (int k = 2; k >= 0; k--) begin
            step(1'b1, s3[k], 1'b0);
            n_total++; if (match !== em3[k]) $display("FAIL err_resume bit%0d got %b want %b", 3 - k, match, em3[k]); else n_pass++;
        end
    endtask

    task automatic test_saturate();
        logic [5:0] em;
        em = 6'b011111;
        load(8'b11, 4'd2, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        for (int k = 5; k >= 0; k--) begin
            step(1'b1, 1'b1, 1'b0);
            n_total++; if (match !== em[k]) $display("FAIL sat_match bit%0d got %b want %b", 6 - k, match, em[k]); else n_pass++;
        end
        n_total++; if (count2 !== 2'd3) $display("FAIL sat_count_w2 got %0d want 3", count2); else n_pass++;
        n_total++; if (match_count !== 8'd5) $display("FAIL sat_count_w8 got %0d want 5", match_count); else n_pass++;
        for (int k = 0; k < 300; k++) step(1'b1, 1'b1, 1'b0);
        n_total++; if (match_count !== 8'd255) $display("FAIL sat_count_255 got %0d want 255", match_count); else n_pass++;
        n_total++; if (count2 !== 2'd3) $display("FAIL sat_count_w2_hold got %0d want 3", count2); else n_pass++;
        step(1'b1, 1'b1, 1'b1);
        n_total++; if (match !== 1'b1) $display("FAIL clr_hit_match got %b want 1", match); else n_pass++;
        n_total++; if (match_count !== 8'd0) $display("FAIL clr_hit_count got %0d want 0", match_count); else n_pass++;
        n_total++; if (count2 !== 2'd0) $display("FAIL clr_hit_count_w2 got %0d want 0", count2); else n_pass++;
        step(1'b1, 1'b1, 1'b0);
        n_total++; if (match_count !== 8'd1) $display("FAIL clr_next_count got %0d want 1", match_count); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [4:0] s, em;
        s = 5'b00100; em = 5'b00001;
        step(1'b1, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        n_total++; if (match !== 1'b0) $display("FAIL rstmid_match got %b want 0", match); else n_pass++;
        n_total++; if (match_count !== 8'd0) $display("FAIL rstmid_count got %0d want 0", match_count); else n_pass++;
        n_total++; if (armed !== 1'b0) $display("FAIL rstmid_armed got %b want 0", armed); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 4; k >= 0; k--) begin
            step(1'b1, s[k], 1'b0);
            n_total++; if (match !== em[k]) $display("FAIL rstmid_stream bit%0d got %b want %b", 5 - k, match, em[k]); else n_pass++;
        end
        n_total++; if (match_count !== 8'd1) $display("FAIL rstmid_final_count got %0d want 1", match_count); else n_pass++;
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        serial_in   = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = 8'd0;
        cfg_len     = 4'd0;
        cfg_overlap = 1'b0;
        cnt_clear   = 1'b0;
        test_reset();
        test_default();
        test_overlap();
        test_nonoverlap();
        test_len8_gaps();
        test_cfg_priority();
        test_cfg_err();
        test_saturate();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Parametrised serial bit-pattern detector. It accepts one qualified serial bit per clock and compares the most recent bits against a run-time programmable pattern of 1..MAX_LEN bits. Overlapping and non-overlapping match modes are supported, and matches are tallied in a saturating counter. It sits behind the serial front end and drives per-pattern event flags to the control logic.

## Interface
Parameters:
- MAX_LEN, 8: maximum pattern length in bits (2..32).
- CNT_W, 8: match counter width.
- DEF_PATTERN, 8'b0000_0100: pattern after reset, LSB-aligned.
- DEF_LEN, 3: pattern length after reset (default detects "100").
- DEF_OVERLAP, 1: overlap mode after reset.

Ports (LEN_W = clog2(MAX_LEN+1)):
- clk, input, 1: single clock; all logic is rising-edge.
- reset, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: serial_in is sampled this cycle.
- serial_in, input, 1: serial data bit.
- cfg_load, input, 1: capture cfg_* this cycle.
- cfg_pattern, input, MAX_LEN: pattern; bit len-1 is the first bit received, bit 0 the last.
- cfg_len, input, LEN_W: pattern length.
- cfg_overlap, input, 1: 1 = overlapping matches, 0 = non-overlapping.
- cnt_clear, input, 1: synchronous clear of match_count.
- match, output, 1: one-cycle pulse, registered.
- match_count, output, CNT_W: saturating match tally.
- armed, output, 1: at least len valid bits are held since the last restart.
- cfg_err, output, 1: the last cfg_load had len 0 or len > MAX_LEN.

## Operation
- History register hist[MAX_LEN-1:0]: on each accepted bit, hist <= {hist[MAX_LEN-2:0], serial_in}.
- fill counter: counts accepted bits since the last restart and saturates at MAX_LEN.
- Compare on the accepted bit: a hit occurs when the new history window hist'[len-1:0] equals pattern[len-1:0] and fill' >= len.
- FSM states:
  - DISABLED: invalid config. in_valid is ignored; no matches.
  - FILLING: fill < len.
  - ARMED: fill >= len.
- Transitions:
  - FILLING -> ARMED when fill reaches len.
  - On a hit in non-overlap mode: fill <= 0, go to FILLING. The completing bit is not reused.
  - On a hit in overlap mode: fill is kept, state stays ARMED.
  - On cfg_load with a valid len: latch the config, hist <= 0, fill <= 0, go to FILLING, cfg_err <= 0.
  - On cfg_load with an invalid len: go to DISABLED, cfg_err <= 1. The pattern registers are still latched.
- cfg_load has priority over in_valid in the same cycle; that bit is discarded.
- match_count increments on each hit and holds at 2^CNT_W-1.
- cnt_clear has priority over an increment in the same cycle: the count becomes 0 and that hit is not counted. match still pulses.
- Pattern bits above len-1 are ignored.
- in_valid = 0 holds all state.

## Timing
- Reset values:
  - match = 0, match_count = 0, armed = 0, cfg_err = 0.
  - hist = 0, fill = 0, state = FILLING.
  - Config = DEF_* values.
- Latency: match is high in the cycle after the rising edge that accepts the completing bit. It is a single-cycle pulse unless the next accepted bit is also a hit.
- Back-to-back hits in overlap mode (for example pattern "11" on a run of 1s) produce a continuous match level, one hit per accepted bit.
- match_count updates on the same edge that raises match.
- armed reflects the registered state (ARMED) and updates on the same edge as fill.
- Reset asserted mid-stream: all outputs clear immediately (asynchronously) and the config reverts to DEF_*. The first accepted bit after release starts a fresh fill.
- A new config takes effect for the first accepted bit after the cfg_load edge.

## Structure
- Package seq_det_pkg holds:
  - The state enum (ST_DISABLED, ST_FILLING, ST_ARMED).
  - The LEN_W computation function.
  - Default constants.
- Sub-module sat_counter (parameter W; ports inc, clr, count) implements match_count.
- History register, fill counter, compare and FSM stay in the top module.

## Test plan
- Defaults, stream 1,0,0,1,0,0 with in_valid=1 -> match pulses after the 3rd and 6th bits; match_count=2; armed=1 from the 3rd bit on.
- cfg_load pattern "101", len 3, overlap=1, stream 1,0,1,0,1 -> matches after bits 3 and 5; count=2.
- Same stream with overlap=0 -> match after bit 3 only; count=1; armed drops to 0 the cycle after the hit.
- MAX_LEN=8, load len 8, pattern 8'hA5, stream 8'hA5 with in_valid gaps -> match one cycle after the 8th accepted bit, unaffected by the gaps.
- cfg_load len 0 -> cfg_err=1 and no matches on any stream; then a valid load -> cfg_err=0 and detection resumes.
- CNT_W=2, five hits -> count saturates at 3. cnt_clear coincident with a hit -> count=0, match=1. Reset asserted mid-pattern -> all outputs 0 within the same cycle and the partial pattern is discarded.
